// File: rtl/view_renderer.sv
// view_renderer
//   Draws a VIEW x VIEW tile window of a 32x32 wall map around the player,
//   one pixel per clock in raster order. The player occupies the centre
//   tile and is drawn with a marker on the edge it faces.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   refresh               redraw request pulse (merged into one pending request while busy)
//   px, py, direction     player cell (signed) and heading (00 E, 01 N, 10 W, 11 S)
//   map_addr, map_rdata   {row, col} lookup into the map; the wall bit returns one cycle later
//   draw_X, draw_Y        pixel coordinate, held while draw_we is low
//   color, draw_we        RGB333 pixel colour and its strobe
//   busy, done            frame in progress, single-cycle completion pulse
module view_renderer #(
  parameter int         CORDW    = 12,
  parameter int         TILE     = 16,
  parameter int         VIEW     = 9,
  parameter int         ORG_X    = 0,
  parameter int         ORG_Y    = 0,
  parameter logic [8:0] C_WALL   = 9'h1C0,
  parameter logic [8:0] C_FLOOR  = 9'h000,
  parameter logic [8:0] C_EDGE   = 9'h049,
  parameter logic [8:0] C_PLAYER = 9'h1F8,
  parameter logic [8:0] C_FACE   = 9'h03F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    refresh,
  input  logic signed [5:0]       px,
  input  logic signed [5:0]       py,
  input  logic [1:0]              direction,
  output logic [9:0]              map_addr,
  input  logic                    map_rdata,
  output logic signed [CORDW-1:0] draw_X,
  output logic signed [CORDW-1:0] draw_Y,
  output logic [8:0]              color,
  output logic                    draw_we,
  output logic                    busy,
  output logic                    done
);

  localparam int S    = VIEW * TILE;
  localparam int PW   = $clog2(S);
  localparam int TW   = $clog2(TILE);
  localparam int XW   = PW - TW;
  localparam int HALF = VIEW / 2;
  localparam int Q    = TILE / 4;
  // Tiny tiles still get a one-pixel facing marker.
  localparam int FQ   = (Q == 0) ? 1 : Q;

  localparam logic [PW-1:0]    LAST        = PW'(S - 1);
  localparam logic [XW-1:0]    CTR         = XW'(HALF);
  localparam logic [6:0]       HALF7       = 7'(HALF);
  localparam logic [TW-1:0]    FACE_LO_MAX = TW'(FQ - 1);
  localparam logic [TW-1:0]    FACE_HI_MIN = TW'(TILE - FQ);
  localparam logic [TW:0]      INNER_MIN   = (TW+1)'(Q);
  localparam logic [TW:0]      INNER_SPAN  = (TW+1)'(TILE - 2 * Q);
  localparam logic [CORDW-1:0] ORG_XC      = CORDW'(ORG_X);
  localparam logic [CORDW-1:0] ORG_YC      = CORDW'(ORG_Y);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;

  state_t            state, state_nx;
  logic              pending;
  logic              flush_cnt;
  logic              start;
  logic              last_pix;
  logic [PW-1:0]     x_cnt, y_cnt;
  logic signed [5:0] lpx, lpy;
  logic [1:0]        ldir;

  logic [XW-1:0]     tx, ty;
  logic [TW-1:0]     sx, sy;
  logic [6:0]        col, row;
  logic              out_of_map;
  logic              centre;
  logic              facing;
  logic [TW:0]       dx, dy;
  logic              inner;

  logic              s1_valid;
  logic [PW-1:0]     s1_x, s1_y;
  logic              s1_edge, s1_face, s1_player;

  assign start    = (state == IDLE) && (refresh || pending);
  assign last_pix = (state == DRAW) && (x_cnt == LAST) && (y_cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; FLUSH covers the two cycles the pixel pipeline needs to drain
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DRAW;
      DRAW:    if (last_pix) state_nx = FLUSH;
      FLUSH:   if (flush_cnt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Cell address of the pixel being issued, in 7-bit two's complement
  always_comb begin
    tx         = x_cnt[PW-1:TW];
    ty         = y_cnt[PW-1:TW];
    sx         = x_cnt[TW-1:0];
    sy         = y_cnt[TW-1:0];
    col        = {lpx[5], lpx} - HALF7 + {{(7-XW){1'b0}}, tx};
    row        = {lpy[5], lpy} - HALF7 + {{(7-XW){1'b0}}, ty};
    out_of_map = (col[6:5] != 2'b00) || (row[6:5] != 2'b00);
  end

  // Player marker geometry inside the centre tile. The inner-half test is done
  // as an offset range compare so a zero-width border does not degenerate.
  always_comb begin
    centre = (tx == CTR) && (ty == CTR);
    case (ldir)
      2'b00:   facing = (sx >= FACE_HI_MIN);
      2'b01:   facing = (sy <= FACE_LO_MAX);
      2'b10:   facing = (sx <= FACE_LO_MAX);
      default: facing = (sy >= FACE_HI_MIN);
    endcase
    dx    = {1'b0, sx} - INNER_MIN;
    dy    = {1'b0, sy} - INNER_MIN;
    inner = (dx < INNER_SPAN) && (dy < INNER_SPAN);
  end

  // Output logic of the FSM
  always_comb begin
    busy     = (state != IDLE);
    map_addr = '0;
    if (state == DRAW) map_addr = {row[4:0], col[4:0]};
  end

  // Request handling: inputs are captured only when a frame is accepted, and
  // any refresh arriving while not accepted collapses into one pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      lpx     <= 6'sd1;
      lpy     <= 6'sd7;
      ldir    <= 2'b00;
    end else if (start) begin
      pending <= 1'b0;
      lpx     <= px;
      lpy     <= py;
      ldir    <= direction;
    end else if (refresh) begin
      pending <= 1'b1;
    end
  end

  // Raster scan counters and the flush timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      flush_cnt <= 1'b0;
    end else begin
      flush_cnt <= (state == FLUSH);
      if (start) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (state == DRAW) begin
        if (x_cnt == LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 1 waits alongside the map read; stage 2 merges the wall bit in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_edge   <= 1'b0;
      s1_face   <= 1'b0;
      s1_player <= 1'b0;
    end else begin
      s1_valid  <= (state == DRAW);
      s1_x      <= x_cnt;
      s1_y      <= y_cnt;
      s1_edge   <= out_of_map;
      s1_face   <= centre && facing;
      s1_player <= centre && inner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_we <= 1'b0;
      draw_X  <= '0;
      draw_Y  <= '0;
      color   <= '0;
      done    <= 1'b0;
    end else begin
      draw_we <= s1_valid;
      done    <= (state == FLUSH) && flush_cnt;
      if (s1_valid) begin
        draw_X <= ORG_XC + {{(CORDW-PW){1'b0}}, s1_x};
        draw_Y <= ORG_YC + {{(CORDW-PW){1'b0}}, s1_y};
        if (s1_face)        color <= C_FACE;
        else if (s1_player) color <= C_PLAYER;
        else if (s1_edge)   color <= C_EDGE;
        else if (map_rdata) color <= C_WALL;
        else                color <= C_FLOOR;
      end
    end
  end

endmodule

// File: tb/tb_view_renderer.sv
// Testbench for view_renderer with TILE=2, VIEW=3 (a 6x6 pixel window).
module tb_view_renderer;

  localparam int NPIX = 36;
  localparam logic [8:0] C_WALL   = 9'h1C0;
  localparam logic [8:0] C_FLOOR  = 9'h000;
  localparam logic [8:0] C_EDGE   = 9'h049;
  localparam logic [8:0] C_PLAYER = 9'h1F8;
  localparam logic [8:0] C_FACE   = 9'h03F;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              refresh = 1'b0;
  logic signed [5:0] px = 6'sd0;
  logic signed [5:0] py = 6'sd0;
  logic [1:0]        direction = 2'b00;
  logic [9:0]        map_addr;
  logic              map_rdata;
  logic signed [11:0] draw_X, draw_Y;
  logic [8:0]        color;
  logic              draw_we, busy, done;

  view_renderer #(.CORDW(12), .TILE(2), .VIEW(3), .ORG_X(0), .ORG_Y(0)) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .px(px), .py(py), .direction(direction),
    .map_addr(map_addr), .map_rdata(map_rdata), .draw_X(draw_X), .draw_Y(draw_Y),
    .color(color), .draw_we(draw_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  bit map_mem [0:1023];

  // Synchronous map memory: data follows the address by one cycle
  always @(posedge clk) map_rdata <= map_mem[map_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y; int col; int cyc;} pix_t;
  pix_t exp_q[$];

  typedef struct {int px; int py; int dir; int wr; int wc; int aidx; int aexp; int prx; int pry; int pcol;} vec_t;
  vec_t vecs[10];

  int n_checks = 0;
  int n_pass = 0;
  int pix_seen = 0;
  logic [8:0] obs [0:5][0:5];

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Reference colour of window pixel (x,y) for a given player state
  function automatic int model_color(int mpx, int mpy, int mdir, int x, int y);
    int tx, ty, sx, sy, col, row;
    bit face;
    tx = x / 2; ty = y / 2; sx = x % 2; sy = y % 2;
    col = mpx - 1 + tx;
    row = mpy - 1 + ty;
    if (tx == 1 && ty == 1) begin
      case (mdir)
        0: face = (sx == 1);
        1: face = (sy == 0);
        2: face = (sx == 0);
        default: face = (sy == 1);
      endcase
      return face ? int'(C_FACE) : int'(C_PLAYER);
    end
    if (col < 0 || col > 31 || row < 0 || row > 31) return int'(C_EDGE);
    return map_mem[row * 32 + col] ? int'(C_WALL) : int'(C_FLOOR);
  endfunction

  task automatic push_frame(input int mpx, input int mpy, input int mdir, input int n);
    pix_t e;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++) begin
        e.x = x; e.y = y;
        e.col = model_color(mpx, mpy, mdir, x, y);
        e.cyc = n + 2 + y * 6 + x;
        exp_q.push_back(e);
      end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 1024; i++) map_mem[i] = 1'b0;
  endtask

  // Pixel monitor: every strobe is matched against the scoreboard
  always @(negedge clk) begin : monitor
    pix_t e;
    if (draw_we) begin
      pix_seen++;
      if (draw_X >= 0 && draw_X < 6 && draw_Y >= 0 && draw_Y < 6) obs[draw_X][draw_Y] = color;
      if (exp_q.size() == 0) begin
        check_output("stray_draw_we", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("pix_x", int'(draw_X), e.x);
        check_output("pix_y", int'(draw_Y), e.y);
        check_output("pix_color", int'(color), e.col);
        if (e.cyc >= 0) check_output("pix_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one refresh and register the expected frame; returns the accept edge
  task automatic apply_stimulus(input int mpx, input int mpy, input int mdir, output int n);
    @(negedge clk);
    px = 6'(mpx); py = 6'(mpy); direction = 2'(mdir);
    refresh = 1'b1;
    n = cyc + 1;
    push_frame(mpx, mpy, mdir, n);
    @(negedge clk);
    refresh = 1'b0;
    check_output("busy_start", busy, 1);
  endtask

  task automatic wait_done(input int n, input int aidx, input int aexp);
    int got;
    got = 0;
    for (int i = 0; i < 80 && got == 0; i++) begin
      if (aidx >= 0 && cyc == n + aidx) check_output("map_addr", map_addr, aexp);
      if (done) begin
        check_output("done_cycle", cyc, n + NPIX + 2);
        check_output("busy_at_done", busy, 0);
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (got == 0) check_output("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      check_output("done_width", done, 0);
      check_output("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n, base, dones, saw_done;

    clear_map();
    vecs[0] = '{5, 5, 0, -1, -1, 0, 'h084, 3, 2, int'(C_FACE)};
    vecs[1] = '{5, 5, 0, -1, -1, 0, 'h084, 2, 3, int'(C_PLAYER)};
    vecs[2] = '{0, 0, 0, -1, -1, 14, 'h000, 1, 4, int'(C_EDGE)};
    vecs[3] = '{5, 5, 0, 4, 6, 4, 'h086, 5, 1, int'(C_WALL)};
    vecs[4] = '{5, 5, 1, -1, -1, 0, 'h084, 3, 2, int'(C_FACE)};
    vecs[5] = '{5, 5, 2, -1, -1, 0, 'h084, 2, 3, int'(C_FACE)};
    vecs[6] = '{5, 5, 3, -1, -1, 0, 'h084, 2, 2, int'(C_PLAYER)};
    vecs[7] = '{31, 31, 0, -1, -1, 0, 'h3DE, 5, 5, int'(C_EDGE)};
    vecs[8] = '{30, 30, 2, 31, 31, 0, 'h3BD, 4, 4, int'(C_WALL)};
    vecs[9] = '{-2, 3, 0, -1, -1, -1, 0, 5, 2, int'(C_EDGE)};

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_draw_we", draw_we, 0);
    check_output("rst_map_addr", map_addr, 0);
    check_output("rst_draw_X", int'(draw_X), 0);
    check_output("rst_draw_Y", int'(draw_Y), 0);
    check_output("rst_color", color, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 10; v++) begin
      clear_map();
      if (vecs[v].wr >= 0) map_mem[vecs[v].wr * 32 + vecs[v].wc] = 1'b1;
      apply_stimulus(vecs[v].px, vecs[v].py, vecs[v].dir, n);
      wait_done(n, vecs[v].aidx, vecs[v].aexp);
      check_output($sformatf("probe_v%0d", v), obs[vecs[v].prx][vecs[v].pry], vecs[v].pcol);
      repeat (2) @(negedge clk);
    end

    // Requests during a frame merge into exactly one extra frame
    clear_map();
    base = pix_seen;
    dones = 0;
    apply_stimulus(5, 5, 0, n);
    push_frame(5, 5, 0, n + 39);
    while (cyc < n + 100) begin
      if (cyc == n + 9 || cyc == n + 19) refresh = 1'b1;
      if (cyc == n + 10 || cyc == n + 20) refresh = 1'b0;
      if (done) dones++;
      @(negedge clk);
    end
    check_output("merged_done_count", dones, 2);
    check_output("merged_pixel_count", pix_seen - base, 72);
    check_output("merged_queue_drained", exp_q.size(), 0);
    check_output("merged_idle", busy, 0);

    // Refresh arriving together with done starts the next frame
    apply_stimulus(5, 5, 0, n);
    while (cyc < n + 38 && cyc < n + 60) @(negedge clk);
    check_output("done_coincident", done, 1);
    refresh = 1'b1;
    push_frame(5, 5, 0, n + 39);
    @(negedge clk);
    refresh = 1'b0;
    wait_done(n + 39, 0, 'h084);

    // Reset in the middle of a frame aborts it
    repeat (2) @(negedge clk);
    apply_stimulus(5, 5, 0, n);
    while (cyc < n + 14) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("abort_draw_we", draw_we, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_map_addr", map_addr, 0);
    exp_q.delete();
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check_output("abort_no_done", saw_done, 0);
    apply_stimulus(5, 5, 0, n);
    wait_done(n, 0, 'h084);
    check_output("after_abort_face", obs[3][2], int'(C_FACE));

    // Inputs changing mid-frame do not disturb the latched player state
    repeat (2) @(negedge clk);
    apply_stimulus(5, 5, 1, n);
    while (cyc < n + 4) @(negedge clk);
    px = 6'sd9; py = 6'sd1; direction = 2'b00;
    wait_done(n, 5, 'h086);
    check_output("latched_face_x2", obs[2][2], int'(C_FACE));
    check_output("latched_face_x3", obs[3][2], int'(C_FACE));
    check_output("latched_player", obs[3][3], int'(C_PLAYER));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/view_renderer.md
VIEW_RENDERER -- requirements
Module: view_renderer

Interface
REQ-001 SHALL have parameters (name, default, meaning): CORDW, 12, signed screen-coordinate width.
REQ-002 SHALL have TILE, 16, tile edge in pixels (power of 2, 2..32); VIEW, 9, window edge in tiles (odd, 3..15).
REQ-003 SHALL have ORG_X / ORG_Y, 0 / 0, screen pixel of window top-left; C_WALL 9'h1C0, C_FLOOR 9'h000, C_EDGE 9'h049, C_PLAYER 9'h1F8, C_FACE 9'h03F.
REQ-004 Ports (name, direction, width, meaning): clk, in, 1, sole clock; rst, in, 1, asynchronous active-high reset.
REQ-005 refresh in 1 redraw request pulse; px, py in 6 signed player cell; direction in 2 (00 E, 01 N, 10 W, 11 S).
REQ-006 map_addr out 10 {row[4:0], col[4:0]} of 32x32 map; map_rdata in 1 (1 = wall), valid the cycle after map_addr.
REQ-007 draw_X, draw_Y out CORDW signed pixel coordinate; color out 9 RGB333; draw_we out 1 pixel valid.
REQ-008 busy out 1 render in progress; done out 1 single-cycle completion pulse.

Function
REQ-009 States SHALL be IDLE, DRAW, FLUSH; IDLE->DRAW on refresh or pending; DRAW->FLUSH after last pixel address issued; FLUSH->IDLE after 2 cycles.
REQ-010 On accepting a request, px, py, direction SHALL be latched; input changes mid-render SHALL not affect the frame.
REQ-011 Pixel scan SHALL be raster order, x fastest, over S = VIEW*TILE square; exactly S*S draw_we cycles per frame, one per cycle, no gaps.
REQ-012 Latency: refresh sampled at edge N -> busy=1 and map_addr for pixel (0,0) from N+1, draw_we for (0,0) at N+3.
REQ-013 Last draw_we SHALL be at N+2+S*S; done=1 and busy=0 at N+3+S*S.
REQ-014 Tile (tx,ty) SHALL map to cell col = px - VIEW/2 + tx, row = py - VIEW/2 + ty, computed in 7-bit signed arithmetic.
REQ-015 Cell outside 0..31 in either axis SHALL be drawn C_EDGE; map_addr for it is don't-care.
REQ-016 In-range cell SHALL be drawn C_WALL if map_rdata=1, else C_FLOOR.
REQ-017 Centre tile (VIEW/2, VIEW/2) SHALL override: pixels within TILE/4 of the facing edge -> C_FACE; remaining pixels within inner half of tile -> C_PLAYER; rest per REQ-015/016.
REQ-018 draw_X = ORG_X + pixel x, draw_Y = ORG_Y + pixel y, sign-extended to CORDW; output registers change only with draw_we.
REQ-019 refresh while busy SHALL set a single pending flag (further requests merge); new frame starts the cycle after done, re-latching inputs then.
REQ-020 refresh coincident with done SHALL be treated as pending, not dropped.
REQ-021 draw_we, done SHALL be 0 outside DRAW/FLUSH; color/draw_X/draw_Y hold last value when draw_we=0.

Reset
REQ-022 rst SHALL asynchronously force IDLE, pending=0, busy=0, done=0, draw_we=0, map_addr=0, draw_X=0, draw_Y=0, color=0.
REQ-023 rst mid-render SHALL abort the frame with no further draw_we or done; first refresh after rst deassertion starts a fresh frame.
REQ-024 Latched player state after reset SHALL be px=1, py=7, direction=00 until first accepted request.

Verification (TILE=2, VIEW=3, ORG=0, S=6)
REQ-025 Map all floor, px=5, py=5, dir=00, refresh at N -> 36 draw_we N+3..N+38, done at N+39; pixels (2..3,2..3) C_PLAYER except x=3 C_FACE, others C_FLOOR.
REQ-026 px=0, py=0 -> tiles tx=0 or ty=0 (pixels x<2 or y<2) C_EDGE; map_addr for tile (1,1) = 10'h000.
REQ-027 Map wall at row 4 col 6, px=5, py=5 -> pixels (4..5,0..1) C_WALL, map_addr includes 10'h086.
REQ-028 Second refresh at N+10 and third at N+20 -> exactly one extra frame, starting N+40, total 72 draw_we.
REQ-029 rst asserted at N+15 -> draw_we and busy 0 immediately, no done pulse; refresh after release -> normal 36-pixel frame.
REQ-030 dir=01 with px changed to 9 at N+5 -> centre-tile y=2 row C_FACE, all pixels reflect px=5.
